// File: rtl/down_ctr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : down_ctr_pkg
// Purpose  : Shared state encoding and width default for the basics-library
//            counters (down_ctr and its incrementing counterpart).
// Revision : 1.0 - initial release
// ============================================================================
package down_ctr_pkg;

  // Counter control states; the encoding is shared with the up-counter.
  typedef enum logic [0:0] {
    STATE_IDLE = 1'b0,
    STATE_RUN  = 1'b1
  } state_t;

  // Default count width used by the library counters.
  localparam int CTR_WIDTH_DEFAULT = 4;

endpackage : down_ctr_pkg
`default_nettype wire

// File: rtl/rc_sub_of_one.sv
`default_nettype none
// ============================================================================
// Module   : rc_sub_of_one
// Purpose  : Combinational ripple-borrow decrement-by-one. borrow_o is the
//            borrow out of the top bit, which is high exactly when i == 0.
// Revision : 1.0 - initial release
// ============================================================================
module rc_sub_of_one #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] i,
  output logic [Width-1:0] result_o,
  output logic             borrow_o
);

  // w_borrow[k] is the borrow into bit k; subtracting one seeds bit 0.
  logic [Width:0] w_borrow;

  assign w_borrow[0] = 1'b1;

  // Each bit flips while a borrow is pending and passes the borrow up
  // only through zero bits.
  for (genvar k = 0; k < Width; k++) begin : g_bit
    assign result_o[k]    = i[k] ^ w_borrow[k];
    assign w_borrow[k+1]  = w_borrow[k] & ~i[k];
  end

  assign borrow_o = w_borrow[Width];

endmodule : rc_sub_of_one
`default_nettype wire

// File: rtl/down_ctr.sv
`default_nettype none
// ============================================================================
// Module   : down_ctr
// Purpose  : Loadable countdown timer. Counts a loaded value down to zero,
//            then returns to IDLE and pulses done_o for one cycle.
// Options  : DOWN_CTR_AUTO_RELOAD_EN - reload the last loaded value instead
//            of stopping at zero, giving a periodic done_o.
// Revision : 1.0 - initial release
// ============================================================================
module down_ctr
  import down_ctr_pkg::*;
#(
  parameter int Width = CTR_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [Width-1:0] o,
  output logic             busy_o,
  output logic             done_o
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [Width-1:0] r_count;
  logic [Width-1:0] w_count_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [Width-1:0] w_dec;
  logic             w_is_zero;
  logic             w_at_one;

`ifdef DOWN_CTR_AUTO_RELOAD_EN
  logic [Width-1:0] r_reload;
  logic [Width-1:0] w_reload_nxt;
`endif

  rc_sub_of_one #(
    .Width (Width)
  ) u_dec (
    .i        (r_count),
    .result_o (w_dec),
    .borrow_o (w_is_zero)
  );

  // The count is one exactly when its decrement is zero.
  assign w_at_one = (w_dec == '0);

  // Next-state, next-count and completion pulse; load beats stop beats start.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
`ifdef DOWN_CTR_AUTO_RELOAD_EN
    w_reload_nxt = r_reload;
`endif
    if (load_i) begin
      w_count_nxt = load_val_i;
      w_state_nxt = STATE_IDLE;
`ifdef DOWN_CTR_AUTO_RELOAD_EN
      w_reload_nxt = load_val_i;
`endif
    end else if (stop_i) begin
      w_state_nxt = STATE_IDLE;
    end else begin
      case (r_state)
        STATE_IDLE: begin
          // Starting from zero would underflow, so it is ignored.
          if (start_i && !w_is_zero) begin
            w_state_nxt = STATE_RUN;
          end
        end
        STATE_RUN: begin
          if (w_is_zero) begin
            // Unreachable in normal operation; never wrap below zero.
            w_state_nxt = STATE_IDLE;
          end else if (w_at_one) begin
            w_done_nxt = 1'b1;
`ifdef DOWN_CTR_AUTO_RELOAD_EN
            w_count_nxt = r_reload;
            w_state_nxt = (r_reload == '0) ? STATE_IDLE : STATE_RUN;
`else
            w_count_nxt = w_dec;
            w_state_nxt = STATE_IDLE;
`endif
          end else begin
            w_count_nxt = w_dec;
          end
        end
        default: w_state_nxt = STATE_IDLE;
      endcase
    end
  end

  // State, count and done registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= STATE_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef DOWN_CTR_AUTO_RELOAD_EN
  // Reload value captured on every load, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_reload <= '0;
    end else begin
      r_reload <= w_reload_nxt;
    end
  end
`endif

  assign o      = r_count;
  assign busy_o = (r_state == STATE_RUN);
  assign done_o = r_done;

endmodule : down_ctr
`default_nettype wire
